ifetch_unit: RTL and testbench

- Fetch stage of the multicycle MIPS CPU, directly upstream of the instruction memory.
- Owns the PC, drives the instruction-memory address, and latches the returned word into an instruction register (IR).
- Computes the next PC (sequential, branch, jump, jr/jalr, exception, eret) when the controller retires the current instruction.
- Counts retired instructions.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/npc_calc.sv | 44 ++++
 rtl/ifetch_unit.sv | 108 ++++++++++
 tb/tb_ifetch_unit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ===========================================================================
// cpu_pkg : shared next-PC encodings, fetch states and address defaults
// Revision: 1.0
// ===========================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [2:0] NPC_SEQ    = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JUMP   = 3'd2;
  localparam logic [2:0] NPC_JREG   = 3'd3;
  localparam logic [2:0] NPC_EXC    = 3'd4;
  localparam logic [2:0] NPC_ERET   = 3'd5;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] DEFAULT_IMEM_BASE  = 32'h0040_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0040_0004;
  localparam logic [31:0] NOP                = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/npc_calc.sv
// ===========================================================================
// npc_calc : combinational next-PC selection for the fetch stage
// Revision: 1.0
// ===========================================================================
`default_nettype none

module npc_calc
  import cpu_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic [31:0] pc,
  input  logic [31:0] ir,
  input  logic [2:0]  npc_sel,
  input  logic [31:0] rs_data,
  input  logic [31:0] epc,
  output logic [31:0] npc,
  output logic [31:0] pc_plus4
);

  logic [31:0] branch_off;
  logic        unused_opcode;

  // The opcode field is decoded by the controller, not here.
  assign unused_opcode = ^ir[31:26];

  assign pc_plus4   = pc + 32'd4;
  assign branch_off = {{14{ir[15]}}, ir[15:0], 2'b00};

  always_comb begin
    npc = pc_plus4;
    case (npc_sel)
      NPC_BRANCH: npc = pc_plus4 + branch_off;
      NPC_JUMP:   npc = {pc_plus4[31:28], ir[25:0], 2'b00};
      NPC_JREG:   npc = rs_data;
      NPC_EXC:    npc = EXC_VECTOR;
      NPC_ERET:   npc = epc;
      default:    npc = pc_plus4;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ifetch_unit.sv
// ===========================================================================
// ifetch_unit : PC/IR ownership, fetch FSM, range check and retire counter
// Revision: 1.0
// ===========================================================================
`default_nettype none

module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter logic [31:0] IMEM_BASE  = DEFAULT_IMEM_BASE,
  parameter int          IMEM_WORDS = 2048,
  parameter logic [31:0] EXC_VECTOR = DEFAULT_EXC_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        stall,
  input  logic        retire,
  input  logic [2:0]  npc_sel,
  input  logic [31:0] rs_data,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] ir,
  output logic        ir_valid,
  output logic        fetch_fault,
  output logic [31:0] inst_count
);

  // One past the last valid byte, kept 33 bits wide so a top-of-space
  // memory does not wrap the comparison.
  localparam logic [32:0] IMEM_END = {1'b0, IMEM_BASE} + 33'(IMEM_WORDS) * 33'd4;

  fetch_state_t state, state_nxt;
  logic [31:0]  npc;
  logic         pc_ok;

  npc_calc #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_npc_calc (
    .pc       (pc),
    .ir       (ir),
    .npc_sel  (npc_sel),
    .rs_data  (rs_data),
    .epc      (epc),
    .npc      (npc),
    .pc_plus4 (pc_plus4)
  );

  assign imem_addr = pc;
  assign pc_ok     = (pc[1:0] == 2'b00) && (pc >= IMEM_BASE) && ({1'b0, pc} < IMEM_END);
  assign ir_valid  = (state != ST_FETCH);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_FETCH: begin
        if (!pc_ok)      state_nxt = ST_FAULT;
        else if (!stall) state_nxt = ST_HOLD;
      end
      ST_HOLD, ST_FAULT: begin
        if (retire) state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      ir          <= NOP;
      fetch_fault <= 1'b0;
      inst_count  <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_FETCH: begin
          if (!pc_ok) begin
            ir          <= NOP;
            fetch_fault <= 1'b1;
          end else if (!stall) begin
            ir <= imem_inst;
          end
        end
        ST_HOLD: begin
          if (retire) begin
            pc         <= npc;
            inst_count <= inst_count + 32'd1;
          end
        end
        ST_FAULT: begin
          // A faulted fetch is not a retired instruction.
          if (retire) begin
            pc          <= npc;
            fetch_fault <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// ===========================================================================
// tb_ifetch_unit : directed self-checking bench for ifetch_unit
// Revision: 1.0
// ===========================================================================
`default_nettype none

module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        stall = 1'b0;
  logic        retire = 1'b0;
  logic [2:0]  npc_sel = 3'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] epc = 32'd0;
  logic [31:0] pc, pc_plus4, ir, inst_count;
  logic        ir_valid, fetch_fault;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] mem [0:15];
  logic [31:0] off;

  always #5 clk = ~clk;

  ifetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_inst   (imem_inst),
    .stall       (stall),
    .retire      (retire),
    .npc_sel     (npc_sel),
    .rs_data     (rs_data),
    .epc         (epc),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .fetch_fault (fetch_fault),
    .inst_count  (inst_count)
  );

  always_comb begin
    off       = imem_addr - 32'h0040_0000;
    imem_inst = 32'd0;
    if (off < 32'd64) imem_inst = mem[off[5:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Retire with the given select, then verify the new PC and fetch latency.
  task automatic do_retire(input logic [2:0] sel, input logic [31:0] rs, input logic [31:0] ep,
                           input logic [31:0] exp_pc, input logic [31:0] exp_ir,
                           input logic exp_fault, input logic [31:0] exp_cnt);
    @(negedge clk);
    retire = 1'b1; npc_sel = sel; rs_data = rs; epc = ep;
    @(posedge clk);
    #1;
    retire = 1'b0; npc_sel = 3'd0;
    chk("pc", pc, exp_pc);
    chk("imem_addr", imem_addr, exp_pc);
    chk("ir_valid_low", {31'd0, ir_valid}, 32'd0);
    chk("inst_count", inst_count, exp_cnt);
    @(posedge clk);
    #1;
    chk("ir_valid_high", {31'd0, ir_valid}, 32'd1);
    chk("ir", ir, exp_ir);
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, exp_fault});
    chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    mem[0] = 32'h2001_0001;
    mem[1] = 32'h0810_0004;
    mem[2] = 32'h1000_FFFF;
    mem[3] = 32'h2402_000A;
    mem[8] = 32'h012A_4020;

    // Reset state
    #12;
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_imem_addr", imem_addr, 32'h0040_0000);
    chk("rst_ir", ir, 32'd0);
    chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_count", inst_count, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("pre_fetch_valid", {31'd0, ir_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("first_valid", {31'd0, ir_valid}, 32'd1);
    chk("first_ir", ir, 32'h2001_0001);
    chk("first_count", inst_count, 32'd0);

    // Sequential retires
    do_retire(3'd0, 32'd0, 32'd0, 32'h0040_0004, 32'h0810_0004, 1'b0, 32'd1);
    do_retire(3'd0, 32'd0, 32'd0, 32'h0040_0008, 32'h1000_FFFF, 1'b0, 32'd2);
    do_retire(3'd0, 32'd0, 32'd0, 32'h0040_000C, 32'h2402_000A, 1'b0, 32'd3);

    // Branch with offset -1 lands back on itself
    do_retire(3'd3, 32'h0040_0008, 32'd0, 32'h0040_0008, 32'h1000_FFFF, 1'b0, 32'd4);
    do_retire(3'd1, 32'd0, 32'd0, 32'h0040_0008, 32'h1000_FFFF, 1'b0, 32'd5);

    // Jump from pc=4 with ir=0x08100004
    do_retire(3'd3, 32'h0040_0004, 32'd0, 32'h0040_0004, 32'h0810_0004, 1'b0, 32'd6);
    do_retire(3'd2, 32'd0, 32'd0, 32'h0040_0010, 32'd0, 1'b0, 32'd7);
    do_retire(3'd3, 32'h0040_0020, 32'd0, 32'h0040_0020, 32'h012A_4020, 1'b0, 32'd8);

    // Misaligned, then out-of-range targets fault; EXC recovers without counting
    do_retire(3'd3, 32'h0040_0022, 32'd0, 32'h0040_0022, 32'd0, 1'b1, 32'd9);
    do_retire(3'd4, 32'd0, 32'd0, 32'h0040_0004, 32'h0810_0004, 1'b0, 32'd9);
    do_retire(3'd3, 32'h0040_2000, 32'd0, 32'h0040_2000, 32'd0, 1'b1, 32'd10);
    do_retire(3'd4, 32'd0, 32'd0, 32'h0040_0004, 32'h0810_0004, 1'b0, 32'd10);

    // Stall in FETCH; retire pulses there are ignored
    @(negedge clk);
    stall = 1'b1; retire = 1'b1; npc_sel = 3'd0;
    @(posedge clk);
    #1 retire = 1'b0;
    chk("stall_pc", pc, 32'h0040_0008);
    chk("stall_count", inst_count, 32'd11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, ir_valid}, 32'd0);
      chk("stall_ir", ir, 32'h0810_0004);
      if (i == 2) begin
        retire = 1'b1; npc_sel = 3'd3; rs_data = 32'h0040_0020;
      end else begin
        retire = 1'b0; npc_sel = 3'd0;
      end
    end
    chk("fetch_retire_pc", pc, 32'h0040_0008);
    chk("fetch_retire_count", inst_count, 32'd11);
    stall = 1'b0;
    @(posedge clk);
    #1;
    chk("unstall_valid", {31'd0, ir_valid}, 32'd1);
    chk("unstall_ir", ir, 32'h1000_FFFF);

    // Asynchronous reset mid-HOLD
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_pc", pc, 32'h0040_0000);
    chk("async_ir", ir, 32'd0);
    chk("async_valid", {31'd0, ir_valid}, 32'd0);
    chk("async_count", inst_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("refetch_ir", ir, 32'h2001_0001);
    chk("refetch_valid", {31'd0, ir_valid}, 32'd1);

    // ERET to epc
    do_retire(3'd5, 32'd0, 32'h0040_0100, 32'h0040_0100, 32'd0, 1'b0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
